pipelined_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It is the successor to the team's single-cycle 32-bit combinational adder. The carry chain is split into `STAGES` equal segments, one register stage per segment, so wide operands close timing at the CPU clock. A valid/ready handshake with whole-pipe stall lets the execute stage, the address generator or the multi-cycle ALU drive it directly. It produces sum, carry-out, signed overflow and zero flags.

---
 rtl/pipelined_adder.sv | 121 ++++++++++++
 tb/tb_pipelined_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor whose carry chain is cut
// into STAGES equal segments, one register stage per segment. A single global
// advance enable freezes the whole pipe when the consumer stalls.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;

    logic              adv;
    logic [STAGES:1]   vld_pipe;

    // The pipe moves as one unit: it advances whenever the output slot is
    // empty or being drained this cycle.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_pipe[STAGES];

    // Valid bits shift alongside the data; empty stages still occupy a slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Operand bits still to be consumed at this stage: segment k and above.
        localparam int AW = WIDTH - k * SEG;

        logic [AW-1:0]          av;
        logic [AW-1:0]          bv;
        logic                   ci;
        logic [SEG-1:0]         seg_sum;
        logic                   seg_co;
        logic [(k+1)*SEG-1:0]   s_nxt;
        logic [(k+1)*SEG-1:0]   s_q;
        logic                   c_q;

        if (k == 0) begin : g_in
            // Subtraction folds into the adder as a + ~b + !cin.
            assign av    = a;
            assign bv    = b ^ {WIDTH{sub}};
            assign ci    = sub ? ~cin : cin;
            assign s_nxt = seg_sum;
        end else begin : g_mid
            assign av    = stg[k-1].g_skew.a_q;
            assign bv    = stg[k-1].g_skew.b_q;
            assign ci    = stg[k-1].c_q;
            assign s_nxt = {seg_sum, stg[k-1].s_q};
        end

        assign {seg_co, seg_sum} = {1'b0, av[SEG-1:0]} + {1'b0, bv[SEG-1:0]}
                                 + {{SEG{1'b0}}, ci};

        // Partial sum (de-skew) and segment carry for the next stage.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_nxt;
                c_q <= seg_co;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [AW-SEG-1:0] a_q;
            logic [AW-SEG-1:0] b_q;

            // Skew registers carry the not-yet-added upper operand segments.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= av[AW-1:SEG];
                    b_q <= bv[AW-1:SEG];
                end
            end
        end else begin : g_flags
            logic ovf_q;
            logic zero_q;

            // Flags are computed from the full sum in the last stage so they
            // register together with the result they describe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= (av[AW-1] == bv[AW-1]) && (seg_sum[SEG-1] != av[AW-1]);
                    zero_q <= (s_nxt == '0);
                end
            end
        end
    end

    assign sum  = stg[STAGES-1].s_q;
    assign cout = stg[STAGES-1].c_q;
    assign ovf  = stg[STAGES-1].g_flags.ovf_q;
    assign zero = stg[STAGES-1].g_flags.zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=32, STAGES=4): directed table, stall and
// reset sequences, then random traffic against an arithmetic reference model.
module tb_pipelined_adder;
    localparam int W = 32;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         r;
    } vec_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference: true integer arithmetic, then range checks for the flags.
    function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb_);
        res_t   r;
        longint ux, uy, sx, sy, lc, ures, sres;
        ux = {32'b0, x};
        uy = {32'b0, y};
        sx = $signed(x);
        sy = $signed(y);
        lc = {63'b0, ci};
        if (sb_) begin
            ures = ux - uy - lc;
            sres = sx - sy - lc;
            r.c  = (ux >= uy + lc);
        end else begin
            ures = ux + uy + lc;
            sres = sx + sy + lc;
            r.c  = (ures >= 64'sd4294967296);
        end
        r.s = ures[31:0];
        r.o = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r.z = (r.s == '0);
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: score the output side, record an accepted beat, advance.
    task automatic step(output bit acc);
        res_t r;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {29'b0, sum, cout, ovf, zero}, 64'hDEAD);
            end else begin
                r = sb.pop_front();
                check("result", {29'b0, sum, cout, ovf, zero}, {29'b0, r});
            end
        end
        acc = in_valid && in_ready;
        if (acc) sb.push_back(model(a, b, cin, sub));
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tab[10];
        bit   acc;
        int   lat;
        int   ntx;
        int   ghosts;
        bit   have_held;
        logic [W-1:0] held;

        tab[0] = '{32'd10,         32'd15,         1'b0, 1'b0, '{32'd25,         1'b0, 1'b0, 1'b0}};
        tab[1] = '{32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0, '{32'd0,          1'b1, 1'b0, 1'b1}};
        tab[2] = '{32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, '{32'h8000_0000,  1'b0, 1'b1, 1'b0}};
        tab[3] = '{32'd5,          32'd7,          1'b0, 1'b1, '{32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0}};
        tab[4] = '{32'd7,          32'd5,          1'b0, 1'b1, '{32'd2,          1'b1, 1'b0, 1'b0}};
        tab[5] = '{32'h8000_0000,  32'd1,          1'b0, 1'b1, '{32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0}};
        tab[6] = '{32'd5,          32'd5,          1'b1, 1'b1, '{32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0}};
        tab[7] = '{32'd5,          32'd5,          1'b0, 1'b1, '{32'd0,          1'b1, 1'b0, 1'b1}};
        tab[8] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, '{32'd0,          1'b1, 1'b1, 1'b1}};
        tab[9] = '{32'h00FF_FFFF,  32'd1,          1'b0, 1'b0, '{32'h0100_0000,  1'b0, 1'b0, 1'b0}};

        // Reset state
        #12;
        check("reset_outputs", {28'b0, out_valid, sum, cout, ovf, zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);

        // Directed table: one beat at a time, latency and value checked
        foreach (tab[i]) begin
            a = tab[i].a; b = tab[i].b; cin = tab[i].cin; sub = tab[i].sub;
            in_valid = 1'b1;
            step(acc);
            in_valid = 1'b0;
            check("table_accept", {63'b0, acc}, 64'd1);
            lat = 0;
            forever begin
                #1;
                if (out_valid || lat > 20) break;
                step(acc);
                lat++;
            end
            check("table_latency", lat, S - 1);
            check("table_value", {29'b0, sum, cout, ovf, zero}, {29'b0, tab[i].r});
            step(acc);
        end

        // Stall: beats k+k, k=1..8, out_ready low during cycles 5..9
        ntx = 0;
        have_held = 1'b0;
        held = '0;
        for (int c = 0; c < 60; c++) begin
            out_ready = !(c >= 5 && c <= 9);
            in_valid  = (ntx < 8);
            a = ntx + 1; b = ntx + 1; cin = 1'b0; sub = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", {63'b0, in_ready}, 64'd0);
                if (have_held) check("stall_hold", {32'b0, sum}, {32'b0, held});
                held = sum;
                have_held = 1'b1;
            end
            step(acc);
            if (acc) ntx++;
            if (ntx == 8 && sb.size() == 0) break;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stall_beats", ntx, 8);
        check("stall_drained", sb.size(), 0);
        check("stall_seen", {63'b0, have_held}, 64'd1);

        // Reset mid-operation: three beats in flight, short reset pulse
        for (int k = 0; k < 3; k++) begin
            a = 20 + k; b = 1; in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_outputs", {29'b0, sum, cout, ovf, zero}, 64'd0);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        ghosts = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) ghosts++;
            step(acc);
        end
        check("rst_ghosts", ghosts, 0);
        a = 3; b = 4; in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        lat = 0;
        forever begin
            #1;
            if (out_valid || lat > 20) break;
            step(acc);
            lat++;
        end
        check("rst_new_latency", lat, S - 1);
        check("rst_new_sum", {32'b0, sum}, 64'd7);
        step(acc);

        // Reset while a result is held at the output
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            a = 100 + k; b = 1; in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_held_drop", {28'b0, out_valid, sum, cout, ovf, zero}, 64'd0);
        #1 rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_held_in_ready", {63'b0, in_ready}, 64'd1);

        // Random traffic with random back-pressure
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rnd_op(); b = rnd_op();
            cin = 1'($urandom); sub = 1'($urandom);
            step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) step(acc);
        check("random_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
